// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_ctrl
//  Description : Control FSM for a 1-in / 3-out packet router. It decodes the
//                header address, sequences FIFO writes through first-data,
//                payload, full-stall and parity phases, and runs a per-channel
//                unread-data watchdog that issues one-cycle soft resets.
//  Revision    : 1.0  - initial release
// ============================================================================
module router_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic [2:0] write_enb,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       fifo_full_sel,
    output logic [2:0] valid_out,
    output logic [2:0] soft_reset
);

    // Watchdog counter width must hold the value TIMEOUT.
    localparam int             CW             = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  c_CNT_LAST     = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  c_CNT_ONE      = CW'(1);
    localparam logic [1:0]     c_ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [1:0]     r_addr;
    logic [CW-1:0]  r_cnt [3];
    logic [2:0]     r_soft_reset;

    logic           w_sel_full;
    logic           w_sel_empty;
    logic           w_sel_soft;
    logic [2:0]     w_addr_onehot;
    logic           w_in_empty;
    logic           w_addr_ok;
    logic           w_write;

    // A header byte is accepted only while a packet is in progress and the
    // address names a real channel.
    assign w_addr_ok = pkt_valid && (data_in != c_ADDR_INVALID);

    // Per-channel status of the latched channel. An explicit case keeps the
    // unused address code 3 from selecting a nonexistent bit.
    always_comb begin
        w_sel_full    = 1'b0;
        w_sel_empty   = 1'b0;
        w_sel_soft    = 1'b0;
        w_addr_onehot = 3'b000;
        case (r_addr)
            2'd0: begin
                w_sel_full    = fifo_full[0];
                w_sel_empty   = fifo_empty[0];
                w_sel_soft    = r_soft_reset[0];
                w_addr_onehot = 3'b001;
            end
            2'd1: begin
                w_sel_full    = fifo_full[1];
                w_sel_empty   = fifo_empty[1];
                w_sel_soft    = r_soft_reset[1];
                w_addr_onehot = 3'b010;
            end
            2'd2: begin
                w_sel_full    = fifo_full[2];
                w_sel_empty   = fifo_empty[2];
                w_sel_soft    = r_soft_reset[2];
                w_addr_onehot = 3'b100;
            end
            default: ;
        endcase
    end

    // Emptiness of the channel addressed by the incoming header byte.
    always_comb begin
        w_in_empty = 1'b0;
        case (data_in)
            2'd0:    w_in_empty = fifo_empty[0];
            2'd1:    w_in_empty = fifo_empty[1];
            2'd2:    w_in_empty = fifo_empty[2];
            default: w_in_empty = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Header address latch; a soft reset on the current channel blocks the
    // decode just as it blocks the state advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr <= 2'd0;
        end else if ((r_state == DECODE_ADDRESS) && w_addr_ok && !w_sel_soft) begin
            r_addr <= data_in;
        end
    end

    // Next-state logic and Moore state decodes.
    always_comb begin
        w_next_state = r_state;
        detect_add   = 1'b0;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        rst_int_reg  = 1'b0;
        busy         = 1'b1;
        w_write      = 1'b0;

        case (r_state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (w_addr_ok) begin
                    w_next_state = w_in_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                lfd_state    = 1'b1;
                w_write      = 1'b1;
                w_next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state = 1'b1;
                busy     = 1'b0;
                w_write  = 1'b1;
                // A full FIFO wins over end-of-packet so no byte is dropped.
                if (w_sel_full) begin
                    w_next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!w_sel_full) begin
                    w_next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                laf_state = 1'b1;
                w_write   = 1'b1;
                if (parity_done) begin
                    w_next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    w_next_state = LOAD_PARITY;
                end else begin
                    w_next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                w_write      = 1'b1;
                w_next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg  = 1'b1;
                w_next_state = w_sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (w_sel_empty) begin
                    w_next_state = LOAD_FIRST_DATA;
                end
            end
            default: begin
                w_next_state = DECODE_ADDRESS;
            end
        endcase

        // The watchdog on the active channel abandons the packet.
        if (w_sel_soft) begin
            w_next_state = DECODE_ADDRESS;
        end
    end

    assign write_enb     = w_write ? w_addr_onehot : 3'b000;
    assign fifo_full_sel = w_sel_full;
    assign valid_out     = ~fifo_empty;
    assign soft_reset    = r_soft_reset;

    // Per-channel unread-data watchdogs: count cycles a channel holds data
    // without being read, and pulse its soft reset when TIMEOUT is reached.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
            r_soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_soft_reset[i] <= 1'b0;
                if (read_enb[i] || !valid_out[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_LAST) begin
                    r_cnt[i]        <= '0;
                    r_soft_reset[i] <= 1'b1;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire
